// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmitter (uart_tx_serializer) and the
// 16x-oversampled receiver.
//
// Contents:
//   OVERSAMPLE_DEFAULT - tick pulses per start/data/parity bit
//   FRAME_BITS_8N1     - line bits in one 8N1 frame (start + 8 data + stop)
//   uart_state_e       - FSM state encoding shared by TX and RX
//
// Build option:
//   UART_TX_PARITY_EN  - adds the PARITY state, widening the encoding to 3 bits
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int FRAME_BITS_8N1     = 10;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;
`endif

endpackage

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
// UART transmitter: serializes DATA_BITS-wide words into start/data/stop
// frames on tx, LSB first. Bit timing comes from the shared 16x oversample
// tick; every start/data/parity bit lasts exactly OVERSAMPLE tick pulses and
// the stop bit lasts STOP_TICKS pulses, regardless of tick spacing.
// A one-entry holding register lets the source queue the next word while a
// frame is on the line, so consecutive frames run with no idle gap.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   tick      in   1-clk oversample strobe (16x baud)
//   tx_valid  in   source has a word
//   tx_data   in   word to send (captured when tx_valid && tx_ready)
//   tx_ready  out  holding register empty
//   tx        out  serial line, registered, idle high
//   tx_busy   out  FSM not in IDLE (registered)
//   tx_done   out  1-clk pulse when a stop bit completes
//
// Build option:
//   UART_TX_PARITY_EN - inserts an even-parity bit between data and stop.
// ----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int STOP_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    uart_state_e          state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [DATA_BITS-1:0] hold_reg;
    logic                 hold_full;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign tx_ready   = !hold_full;
    assign accept     = tx_valid && !hold_full;
    // Next data bit to drive after a shift; used so tx can be updated in the
    // same edge as the shift and stay a pure register output.
    assign shift_next = shift_reg >> 1;

    // NOTE: all state, including the data registers, uses non-blocking
    // assignments in one clocked block; the async reset clears every flop so
    // a reset mid-frame also drops the pending held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;

            // Accept and unload are mutually exclusive: unload needs
            // hold_full=1, accept needs hold_full=0.
            if (accept) begin
                hold_reg  <= tx_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    // Leaving IDLE does not wait for a tick.
                    if (hold_full) begin
                        shift_reg <= hold_reg;
                        hold_full <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^hold_reg;
`endif
                        state     <= START;
                        tx        <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            state    <= DATA;
                            tx       <= shift_reg[0];
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= shift_next;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                                state   <= PARITY;
                                tx      <= parity_bit;
`else
                                state   <= STOP;
                                tx      <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                tx      <= shift_next[0];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            state    <= STOP;
                            tx       <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (tick) begin
                        if (tick_cnt == STOP_LAST) begin
                            tick_cnt <= '0;
                            tx_done  <= 1'b1;
                            // A queued word starts straight away: the stop
                            // bit is followed by the next start bit.
                            if (hold_full) begin
                                shift_reg <= hold_reg;
                                hold_full <= 1'b0;
`ifdef UART_TX_PARITY_EN
                                parity_bit <= ^hold_reg;
`endif
                                state     <= START;
                                tx        <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                tx      <= 1'b1;
                                tx_busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
